// File: rtl/clk_div_gen_if.sv
// Control and output bundle for clk_div_gen.
// The master side owns the run enables and the divisor load port.
// The slave side (the divider) drives the divided clocks, the clock-enable
// pulses and the load-reject pulse.
interface clk_div_gen_if #(
    parameter int NUM_CH   = 4,
    parameter int DIV_BITS = 8
);
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]   ch_en;
    logic                div_load;
    logic [CH_BITS-1:0]  div_ch;
    logic [DIV_BITS-1:0] div_val;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   ce_out;
    logic                div_err;

    modport master (
        output ch_en,
        output div_load,
        output div_ch,
        output div_val,
        input  clk_out,
        input  ce_out,
        input  div_err
    );

    modport slave (
        input  ch_en,
        input  div_load,
        input  div_ch,
        input  div_val,
        output clk_out,
        output ce_out,
        output div_err
    );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH independent integer clock dividers off clk_100m.
// Each channel produces a registered divided square wave (clk_out) and a
// one-cycle clock enable (ce_out) at the start of every divided period.
// Divisor changes on a running channel are staged in a shadow register and
// take effect at the next terminal count, so a period is never truncated.
//
// Optional feature macro: CLK_DIV_ODD_DUTY50_EN
//   defined   - odd divisors get a 50% duty cycle by OR-ing the rising-edge
//               output with a falling-edge retimed copy of it.
//   undefined - no negedge logic; odd N is high (N+1)/2 cycles, low (N-1)/2.
//
// Per-channel FSM:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | stopped; clk_out=0, loads go straight to the active divisor
//   ST_RUN  | counting 0..N-1; loads go to the shadow, applied at the wrap
module clk_div_gen #(
    parameter int NUM_CH   = 4,
    parameter int DIV_BITS = 8,
    parameter int DIV_INIT = 4
) (
    input  logic            clk_100m,
    input  logic            reset,
    clk_div_gen_if.slave    bus
);

    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_BITS:0]    NUM_CH_W = (CH_BITS + 1)'(NUM_CH);
    localparam logic [DIV_BITS-1:0] DIV_RST  = DIV_BITS'(DIV_INIT);
    localparam logic [DIV_BITS-1:0] DIV_MIN  = DIV_BITS'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    logic                load_ok;
    logic                load_bad;
    logic                div_err_q;
    logic [NUM_CH-1:0]   clk_vec;
    logic [NUM_CH-1:0]   ce_vec;

    // A load is accepted only for a real channel and a divisor of at least 2.
    assign load_ok  = bus.div_load
                      && (bus.div_val >= DIV_MIN)
                      && ({1'b0, bus.div_ch} < NUM_CH_W);
    assign load_bad = bus.div_load && !load_ok;

    // Registered reject pulse, one cycle after the offending strobe.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            div_err_q <= 1'b0;
        end else begin
            div_err_q <= load_bad;
        end
    end

    assign bus.div_err = div_err_q;
    assign bus.clk_out = clk_vec;
    assign bus.ce_out  = ce_vec;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t           st_q;
        ch_state_t           st_d;
        logic [DIV_BITS-1:0] cnt_q;
        logic [DIV_BITS-1:0] cnt_d;
        logic [DIV_BITS-1:0] n_q;
        logic [DIV_BITS-1:0] n_d;
        logic [DIV_BITS-1:0] shd_q;
        logic [DIV_BITS-1:0] shd_d;
        logic                pend_q;
        logic                pend_d;
        logic                clk_q;
        logic                clk_d;
        logic                ce_q;
        logic                ce_d;
        logic                sel;
        logic                tc;
        logic [DIV_BITS-1:0] hi_len;

        assign sel = load_ok && (bus.div_ch == CH_BITS'(c));
        assign tc  = (cnt_q == (n_q - 1'b1));

`ifdef CLK_DIV_ODD_DUTY50_EN
        // Rising-edge part stays high floor(N/2) cycles; the negedge copy
        // adds the missing half cycle for odd N.
        assign hi_len = n_q >> 1;
`else
        // High for ceil(N/2) cycles.
        assign hi_len = (n_q >> 1) + {{(DIV_BITS-1){1'b0}}, n_q[0]};
`endif

        // Channel state, counter, divisors and registered outputs.
        always_ff @(posedge clk_100m or posedge reset) begin
            if (reset) begin
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                n_q    <= DIV_RST;
                shd_q  <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                ce_q   <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                n_q    <= n_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                ce_q   <= ce_d;
            end
        end

        // Next-state, divisor staging and output decode.
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            n_d    = n_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            clk_d  = 1'b0;
            ce_d   = 1'b0;
            unique case (st_q)
                ST_IDLE: begin
                    // A load that landed on the going-idle wrap is still in
                    // the shadow; promote it so the next start uses it.
                    if (pend_q) begin
                        n_d    = shd_q;
                        pend_d = 1'b0;
                    end
                    if (bus.ch_en[c]) begin
                        st_d  = ST_RUN;
                        cnt_d = '0;
                        clk_d = 1'b1;
                        ce_d  = 1'b1;
                    end
                    if (sel) begin
                        n_d = bus.div_val;
                    end
                end
                ST_RUN: begin
                    if (tc) begin
                        cnt_d = '0;
                        if (pend_q) begin
                            n_d    = shd_q;
                            pend_d = 1'b0;
                        end
                        if (bus.ch_en[c]) begin
                            clk_d = 1'b1;
                            ce_d  = 1'b1;
                        end else begin
                            st_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        clk_d = (cnt_d < hi_len);
                    end
                    // Set after the wrap handling so a load on the TC edge
                    // waits for the following wrap.
                    if (sel) begin
                        shd_d  = bus.div_val;
                        pend_d = 1'b1;
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end

`ifdef CLK_DIV_ODD_DUTY50_EN
        logic clk_ng_q;

        // Half-cycle delayed copy of the output, only for odd divisors.
        always_ff @(negedge clk_100m or posedge reset) begin
            if (reset) begin
                clk_ng_q <= 1'b0;
            end else begin
                clk_ng_q <= clk_q & n_q[0];
            end
        end

        assign clk_vec[c] = clk_q | clk_ng_q;
`else
        assign clk_vec[c] = clk_q;
`endif
        assign ce_vec[c] = ce_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen (default build, odd-duty feature off).
// Expected per-cycle {clk_out, ce_out, div_err} triples are queued when the
// stimulus is applied and popped as each cycle of DUT output is sampled.
module tb_clk_div_gen;

    localparam int NUM_CH   = 3;
    localparam int DIV_BITS = 8;
    localparam int DIV_INIT = 4;

    logic clk_100m = 1'b0;
    logic reset    = 1'b1;

    clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_BITS(DIV_BITS)) bus();

    clk_div_gen #(
        .NUM_CH  (NUM_CH),
        .DIV_BITS(DIV_BITS),
        .DIV_INIT(DIV_INIT)
    ) dut (
        .clk_100m(clk_100m),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_100m = ~clk_100m;

    typedef logic [2:0] exp_t;   // {clk_out[ch], ce_out[ch], div_err}
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic push_period(input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back({(k < (n + 1) / 2) ? 1'b1 : 1'b0,
                          (k == 0) ? 1'b1 : 1'b0, 1'b0});
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sb.push_back(3'b000);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.ch_en    = '0;
        bus.div_load = 1'b0;
        bus.div_ch   = '0;
        bus.div_val  = '0;
        sb.delete();
        repeat (2) @(negedge clk_100m);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.ch_en    = '1;
        bus.div_load = 1'b0;
        bus.div_ch   = '0;
        bus.div_val  = '0;
        #1;
        n_cmp++;
        if (bus.clk_out !== '0) begin
            n_mis++; $display("FAIL reset_clk: got %b want 000", bus.clk_out);
        end
        n_cmp++;
        if (bus.ce_out !== '0) begin
            n_mis++; $display("FAIL reset_ce: got %b want 000", bus.ce_out);
        end
        n_cmp++;
        if (bus.div_err !== 1'b0) begin
            n_mis++; $display("FAIL reset_err: got %b want 0", bus.div_err);
        end
        repeat (3) @(negedge clk_100m);
        n_cmp++;
        if ({bus.clk_out, bus.ce_out} !== '0) begin
            n_mis++; $display("FAIL reset_held: got %b want 000000", {bus.clk_out, bus.ce_out});
        end
        do_reset();
    endtask

    task automatic test_basic();
        exp_t e, o;
        @(negedge clk_100m);
        bus.ch_en[0] = 1'b1;
        push_period(4); push_period(4); push_period(4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[0], bus.ce_out[0], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL basic cyc %0d: got %b want %b", i, o, e);
            end
        end
        do_reset();
    endtask

    task automatic test_shadow();
        exp_t e, o;
        @(negedge clk_100m);
        bus.ch_en[1] = 1'b1;
        push_period(4); push_period(6); push_period(6);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[1], bus.ce_out[1], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL shadow cyc %0d: got %b want %b", i, o, e);
            end
            if (i == 1) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd6;
            end else begin
                bus.div_load = 1'b0;
            end
        end
        do_reset();
    endtask

    task automatic test_err();
        exp_t e, o;
        @(negedge clk_100m);
        bus.ch_en[0] = 1'b1;
        push_period(4); push_period(4); push_period(4);
        sb[2] = sb[2] | 3'b001;
        sb[5] = sb[5] | 3'b001;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[0], bus.ce_out[0], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL err cyc %0d: got %b want %b", i, o, e);
            end
            if (i == 1) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_val = 8'd1;
            end else if (i == 4) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd3; bus.div_val = 8'd6;
            end else begin
                bus.div_load = 1'b0;
            end
        end
        do_reset();
    endtask

    task automatic test_odd_drop();
        exp_t e, o;
        int   hi;
        hi = 0;
        @(negedge clk_100m);
        bus.div_load = 1'b1; bus.div_ch = 2'd2; bus.div_val = 8'd5;
        @(negedge clk_100m);
        bus.div_load = 1'b0;
        bus.ch_en[2] = 1'b1;
        push_period(5); push_idle(6);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[2], bus.ce_out[2], bus.div_err};
            if (i < 5 && bus.clk_out[2] === 1'b1) hi++;
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL odd_drop cyc %0d: got %b want %b", i, o, e);
            end
            if (i == 1) bus.ch_en[2] = 1'b0;
        end
        n_cmp++;
        if (hi !== 3) begin
            n_mis++; $display("FAIL odd_high_time: got %0d want 3", hi);
        end
        do_reset();
    endtask

    task automatic test_tc_load();
        exp_t e, o;
        @(negedge clk_100m);
        bus.ch_en[0] = 1'b1;
        push_period(4); push_period(4); push_period(5); push_period(5);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[0], bus.ce_out[0], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL tc_load cyc %0d: got %b want %b", i, o, e);
            end
            if (i == 3) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_val = 8'd6;
            end else if (i == 5) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd0; bus.div_val = 8'd5;
            end else begin
                bus.div_load = 1'b0;
            end
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        @(negedge clk_100m);
        bus.ch_en[1] = 1'b1;
        push_period(4); push_idle(3); push_period(2); push_period(2);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[1], bus.ce_out[1], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, o, e);
            end
            if (i == 1) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd2;
            end else begin
                bus.div_load = 1'b0;
            end
            if (i == 3) bus.ch_en[1] = 1'b0;
            if (i == 6) bus.ch_en[1] = 1'b1;
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        @(negedge clk_100m);
        bus.div_load = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd6;
        @(negedge clk_100m);
        bus.div_load = 1'b0;
        bus.ch_en[1] = 1'b1;
        sb.push_back(3'b110); sb.push_back(3'b100); sb.push_back(3'b100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[1], bus.ce_out[1], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL reset_mid pre cyc %0d: got %b want %b", i, o, e);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.clk_out, bus.ce_out, bus.div_err} !== '0) begin
            n_mis++; $display("FAIL reset_mid_async: got %b want 0000000",
                              {bus.clk_out, bus.ce_out, bus.div_err});
        end
        repeat (2) @(negedge clk_100m);
        reset = 1'b0;
        push_period(4); push_period(4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_100m); #1;
            e = sb.pop_front();
            o = {bus.clk_out[1], bus.ce_out[1], bus.div_err};
            n_cmp++;
            if (o !== e) begin
                n_mis++; $display("FAIL reset_mid post cyc %0d: got %b want %b", i, o, e);
            end
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_err();
        test_odd_drop();
        test_tc_load();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels, legal range 1..16.
REQ-002 Parameter DIV_BITS, default 8, width of each divisor value N.
REQ-003 Parameter DIV_INIT, default 4, active divisor of every channel after reset; the legal range is 2..2^DIV_BITS-1.
REQ-004 Derived CH_BITS = max(1, ceil(log2(NUM_CH))).
REQ-005 clk_100m  input  1  sole clock; all logic is rising-edge, except the negedge stage in REQ-024.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ch_en  input  NUM_CH  per-channel run enable, level.
REQ-008 div_load  input  1  single-cycle divisor load strobe.
REQ-009 div_ch  input  CH_BITS  channel targeted by div_load.
REQ-010 div_val  input  DIV_BITS  divisor N for div_load.
REQ-011 clk_out  output  NUM_CH  registered divided square wave per channel, destined for a BUFG.
REQ-012 ce_out  output  NUM_CH  single-cycle clock-enable pulse at the start of each divided period.
REQ-013 div_err  output  1  single-cycle pulse on a rejected load.

Function
REQ-014 Each channel SHALL hold a state (IDLE/RUN), a counter cnt (0..N-1), an active divisor N and a shadow divisor with a pending flag.
REQ-015 IDLE: with ch_en=1 sampled at edge k, the channel enters RUN and cnt=0, clk_out=1 and ce_out=1 after edge k; otherwise clk_out=0 and ce_out=0.
REQ-016 RUN: cnt increments by 1 each cycle; at cnt=N-1 it wraps to 0 (the terminal count, TC).
REQ-017 clk_out is 1 while cnt < ceil(N/2), else 0; an even N gives a 50% duty cycle; an odd N gives (N+1)/2 cycles high and (N-1)/2 low.
REQ-018 ce_out is 1 exactly in the cycles where cnt=0 in RUN.
REQ-019 Deasserting ch_en does not truncate a period; the channel returns to IDLE at the next TC, with clk_out=0 and no ce_out pulse after the TC.
REQ-020 Loads: div_load with div_val<2 or div_ch>=NUM_CH is ignored and pulses div_err the next cycle; otherwise:
  - target IDLE: the value goes directly to the active N;
  - target RUN: the value goes to the shadow and the pending flag is set.
REQ-021 At TC, a pending shadow is copied to the active N and the pending flag clears; the new N governs the period that starts at that wrap.
REQ-022 Simultaneous events:
  - a load on the same edge as a TC goes to the shadow and applies at the following TC;
  - a second load before TC overwrites the shadow (last wins);
  - ch_en=0 at TC with a pending shadow applies the shadow and then goes IDLE.
REQ-023 All outputs are flop-driven; no combinational path runs from inputs to clk_out or ce_out.

Configuration
REQ-024 Macro CLK_DIV_ODD_DUTY50_EN:
  - defined: for odd N, clk_out is the OR of the rising-edge output and a copy of it retimed on the falling edge of clk_100m, giving exactly N/2 clk_100m periods high (50%); even N is unchanged;
  - undefined: no negedge logic exists and REQ-017 applies as written.

Reset
REQ-025 Reset asserted: all channels go IDLE immediately, cnt=0, active N=DIV_INIT, shadows cleared and pending flags cleared; clk_out, ce_out and div_err are 0 without waiting for a clock edge.
REQ-026 Reset asserted mid-period aborts that period without completing it; after release, channels obey REQ-015 on the first edge with ch_en=1.

Verification
REQ-027 Reset release, ch_en[0]=1 with DIV_INIT=4 -> clk_out[0] pattern 1,1,0,0 repeating; ce_out[0] high every 4th cycle, first in the cycle after the enable edge.
REQ-028 Ch1 running with N=4, load div_ch=1, div_val=6 at cnt=1 -> the current period stays 4 cycles; the next period is 6 cycles (3 high, 3 low); the pending flag clears at that TC.
REQ-029 Load div_val=1, then load div_ch=NUM_CH -> div_err pulses once for each load; all channels' N and timing are unchanged.
REQ-030 Ch2 with N=5, ch_en dropped at cnt=1 -> output completes 1,1,1,0,0, then holds 0 with no further ce_out.
REQ-031 N=5, CLK_DIV_ODD_DUTY50_EN defined -> high time 2.5 clk_100m periods per 5-cycle period; undefined -> high time 3 periods.
REQ-032 Reset pulsed at cnt=2 of a 6-cycle period -> clk_out and ce_out go 0 asynchronously; after release, N=DIV_INIT and restart per REQ-015.
